// File: rtl/m2v_stcode_if.sv
// Stream-side and consumer-side signals of the m2v_stcode start-code scanner.
// master: the scanner. slave: the stream buffer and header parser around it.
interface m2v_stcode_if #(
  parameter int SKIPCNT_WIDTH = 16
);
  logic [12:0]              buffer_data;
  logic                     buffer_valid;
  logic                     parser_shift;
  logic [3:0]               parser_width;
  logic                     parser_align;
  logic                     search_start;
  logic                     search_busy;
  logic                     code_valid;
  logic [7:0]               code_value;
  logic                     code_ack;
  logic [SKIPCNT_WIDTH-1:0] skip_count;

  modport master (
    input  buffer_data, buffer_valid, search_start, code_ack,
    output parser_shift, parser_width, parser_align,
           search_busy, code_valid, code_value, skip_count
  );

  modport slave (
    output buffer_data, buffer_valid, search_start, code_ack,
    input  parser_shift, parser_width, parser_align,
           search_busy, code_valid, code_value, skip_count
  );
endinterface

// File: rtl/m2v_stcode.sv
// m2v_stcode: MPEG2 start-code scanner fed by the stream buffer.
// Byte-aligns, hunts for 00 00 01, captures the following byte and holds it
// until the header parser acknowledges.
// Optional: define M2V_STCODE_SKIPCNT_EN to count bytes discarded before the
// prefix; otherwise skip_count is tied to zero.
//
// state | meaning
// IDLE  | waiting for search_start
// ALIGN | one align strobe to the next byte boundary
// SCAN  | consuming bytes, tracking the zero run
// CODE  | consuming the byte after the prefix
// FOUND | code_value presented, waiting for code_ack
module m2v_stcode #(
  parameter int SKIPCNT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         softreset,
  m2v_stcode_if.master bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, SCAN, CODE, FOUND} state_t;

  state_t      state;
  logic [1:0]  zcnt;
  logic        code_valid_q;
  logic [7:0]  code_value_q;
  logic [7:0]  cur_byte;

  assign cur_byte = bus.buffer_data[12:5];

  // The buffer acts on these strobes in the same cycle, so they stay combinational.
  assign bus.parser_width = 4'd8;
  assign bus.parser_align = !softreset && (state == ALIGN) && bus.buffer_valid;
  assign bus.parser_shift = !softreset && ((state == SCAN) || (state == CODE))
                            && bus.buffer_valid;
  assign bus.search_busy  = (state == ALIGN) || (state == SCAN) || (state == CODE);
  assign bus.code_valid   = code_valid_q;
  assign bus.code_value   = code_value_q;

  // Main sequencer: alignment, prefix detection and code hand-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      zcnt         <= 2'd0;
      code_valid_q <= 1'b0;
      code_value_q <= 8'h00;
    end else if (softreset) begin
      state        <= IDLE;
      zcnt         <= 2'd0;
      code_valid_q <= 1'b0;
      code_value_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.search_start) begin
            state <= ALIGN;
            zcnt  <= 2'd0;
          end
        end
        ALIGN: begin
          if (bus.buffer_valid) state <= SCAN;
        end
        SCAN: begin
          if (bus.buffer_valid) begin
            if (cur_byte == 8'h00) begin
              if (zcnt != 2'd2) zcnt <= zcnt + 2'd1;
            end else if ((cur_byte == 8'h01) && (zcnt == 2'd2)) begin
              state <= CODE;
              zcnt  <= 2'd0;
            end else begin
              zcnt <= 2'd0;
            end
          end
        end
        CODE: begin
          if (bus.buffer_valid) begin
            code_value_q <= cur_byte;
            code_valid_q <= 1'b1;
            state        <= FOUND;
          end
        end
        FOUND: begin
          if (bus.code_ack) begin
            code_valid_q <= 1'b0;
            zcnt         <= 2'd0;
            state        <= bus.search_start ? ALIGN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef M2V_STCODE_SKIPCNT_EN
  logic [SKIPCNT_WIDTH-1:0] skip_q;
  logic                     skip_clr;
  logic                     skip_brk;
  logic [SKIPCNT_WIDTH:0]   skip_sum;

  // A fresh search clears the count; a broken run discards the pending zeros
  // plus the byte that broke it. Extra leading zeros are held in the saturated
  // zcnt and so never reach the count.
  assign skip_clr = ((state == IDLE) && bus.search_start) ||
                    ((state == FOUND) && bus.code_ack && bus.search_start);
  assign skip_brk = (state == SCAN) && bus.buffer_valid && (cur_byte != 8'h00) &&
                    !((cur_byte == 8'h01) && (zcnt == 2'd2));
  assign skip_sum = {1'b0, skip_q} + (SKIPCNT_WIDTH + 1)'({1'b0, zcnt} + 3'd1);

  // Saturating skipped-byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_q <= '0;
    end else if (softreset || skip_clr) begin
      skip_q <= '0;
    end else if (skip_brk && !softreset) begin
      skip_q <= skip_sum[SKIPCNT_WIDTH] ? '1 : skip_sum[SKIPCNT_WIDTH-1:0];
    end
  end

  assign bus.skip_count = skip_q;
`else
  assign bus.skip_count = '0;
`endif

endmodule

// File: tb/tb_m2v_stcode.sv
// Self-checking bench for m2v_stcode with a bit-level stream buffer model and
// a scoreboard of expected start codes.
module tb_m2v_stcode;
  localparam int W = 16;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0]   code;
    logic [W-1:0] skip;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic softreset;

  always #5 clk = ~clk;

  m2v_stcode_if #(.SKIPCNT_WIDTH(W)) bus ();

  m2v_stcode #(.SKIPCNT_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .softreset (softreset),
    .bus       (bus)
  );

  logic bits [0:1023];
  int   nbits    = 0;
  int   ptr      = 0;
  logic load_req = 1'b0;
  int   load_val = 0;
  logic stall    = 1'b0;

  int nshift = 0, nalign = 0, nboth = 0, nbad = 0;
  int n_checks = 0, n_pass = 0;
  exp_t sbq[$];

  // Stream buffer pointer model.
  always @(posedge clk) begin
    if (load_req)              ptr <= load_val;
    else if (bus.parser_shift) ptr <= ptr + 8;
    else if (bus.parser_align) ptr <= (ptr + 7) & ~7;
  end

  // Strobe monitors.
  always @(posedge clk) begin
    if (bus.parser_shift) nshift <= nshift + 1;
    if (bus.parser_align) nalign <= nalign + 1;
    if (bus.parser_shift && bus.parser_align) nboth <= nboth + 1;
    if ((bus.parser_shift || bus.parser_align) && !bus.buffer_valid) nbad <= nbad + 1;
  end

  // 13-bit MSB-first window at the pointer.
  always_comb begin
    bus.buffer_data  = '0;
    bus.buffer_valid = 1'b0;
    for (int i = 0; i < 13; i++)
      bus.buffer_data[12-i] = (ptr + i < nbits) ? bits[ptr+i] : 1'b0;
    bus.buffer_valid = (ptr + 13 <= nbits) && !stall;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load(input byte_q_t bq, input int offset);
    for (int b = 0; b < bq.size(); b++)
      for (int k = 0; k < 8; k++) bits[b*8+k] = bq[b][7-k];
    nbits    = 8 * bq.size();
    load_val = offset;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] code, input logic [W-1:0] skip);
    exp_t e;
    e.code = code;
`ifdef M2V_STCODE_SKIPCNT_EN
    e.skip = skip;
`else
    e.skip = '0;
`endif
    sbq.push_back(e);
  endtask

  // Pulse search_start from a negedge; returns with cyc = 1 (one edge seen).
  task automatic start_pulse(output int cyc);
    bus.search_start = 1'b1;
    @(negedge clk);
    bus.search_start = 1'b0;
    cyc = 1;
  endtask

  // Wait for code_valid, optionally stalling the buffer once after stall_at shifts.
  task automatic wait_code(input string tag, input int s0, input int stall_at,
                           input int stall_len, inout int cyc);
    bit done = 1'b0;
    int snap;
    while (!bus.code_valid && cyc < 300) begin
      if (!done && stall_len > 0 && (nshift - s0) == stall_at) begin
        stall = 1'b1;
        snap  = nshift;
        repeat (stall_len) @(negedge clk);
        cyc  += stall_len;
        chk({tag, " no shift in stall"}, nshift, snap);
        chk({tag, " busy in stall"}, bus.search_busy, 1);
        stall = 1'b0;
        done  = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, " code_valid"}, bus.code_valid, 1);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, " scoreboard entry"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({tag, " code_value"}, bus.code_value, e.code);
      chk({tag, " skip_count"}, bus.skip_count, e.skip);
    end
  endtask

  task automatic wait_shifts(input string tag, input int s0, input int n);
    int c = 0;
    while ((nshift - s0) < n && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " shift progress"}, nshift - s0, n);
  endtask

  task automatic ack();
    bus.code_ack = 1'b1;
    @(negedge clk);
    bus.code_ack = 1'b0;
    chk("ack code_valid", bus.code_valid, 0);
    chk("ack busy", bus.search_busy, 0);
  endtask

  initial begin
    int cyc, s0, a0, snap;
    byte_q_t bq;

    reset            = 1'b1;
    softreset        = 1'b0;
    bus.search_start = 1'b0;
    bus.code_ack     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", bus.search_busy, 0);
    chk("rst code_valid", bus.code_valid, 0);
    chk("rst code_value", bus.code_value, 8'h00);
    chk("rst skip", bus.skip_count, 0);
    chk("rst shift", bus.parser_shift, 0);
    chk("rst align", bus.parser_align, 0);
    chk("width", bus.parser_width, 4'd8);
    reset = 1'b0;
    @(negedge clk);

    // Aligned prefix at the first byte.
    bq = {8'h00, 8'h00, 8'h01, 8'hB3, 8'hFF, 8'hFF};
    load(bq, 0);
    s0 = nshift;
    push_exp(8'hB3, 0);
    start_pulse(cyc);
    wait_code("t1", s0, 0, 0, cyc);
    chk("t1 latency", cyc, 6);
    chk("t1 shifts", nshift - s0, 4);
    chk("t1 busy", bus.search_busy, 0);
    pop_cmp("t1");
    snap = nshift;
    repeat (3) @(negedge clk);
    chk("t1 hold valid", bus.code_valid, 1);
    chk("t1 hold value", bus.code_value, 8'hB3);
    chk("t1 hold no shift", nshift, snap);
    ack();

    // Misaligned pointer, junk byte then stuffed prefix.
    bq = {8'hA5, 8'h47, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF};
    load(bq, 3);
    s0 = nshift;
    a0 = nalign;
    push_exp(8'h00, 1);
    start_pulse(cyc);
    wait_code("t2", s0, 0, 0, cyc);
    chk("t2 aligns", nalign - a0, 1);
    chk("t2 shifts", nshift - s0, 6);
    pop_cmp("t2");
    ack();

    // False prefixes.
    bq = {8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'hB8, 8'hFF, 8'hFF};
    load(bq, 0);
    s0 = nshift;
    push_exp(8'hB8, 5);
    start_pulse(cyc);
    wait_code("t3", s0, 0, 0, cyc);
    chk("t3 shifts", nshift - s0, 9);
    pop_cmp("t3");
    ack();

    // Ten-cycle stall after 00 00.
    bq = {8'h00, 8'h00, 8'h01, 8'hB5, 8'hFF, 8'hFF};
    load(bq, 0);
    s0 = nshift;
    push_exp(8'hB5, 0);
    start_pulse(cyc);
    wait_code("t4", s0, 2, 10, cyc);
    chk("t4 latency", cyc, 16);
    chk("t4 shifts", nshift - s0, 4);
    pop_cmp("t4");
    ack();

    // Back-to-back: ack and start together in FOUND.
    bq = {8'h00, 8'h00, 8'h01, 8'hB3, 8'h00, 8'h00, 8'h01, 8'hB7, 8'hFF, 8'hFF};
    load(bq, 0);
    s0 = nshift;
    push_exp(8'hB3, 0);
    start_pulse(cyc);
    wait_code("t5a", s0, 0, 0, cyc);
    pop_cmp("t5a");
    push_exp(8'hB7, 0);
    bus.code_ack     = 1'b1;
    bus.search_start = 1'b1;
    @(negedge clk);
    bus.code_ack     = 1'b0;
    bus.search_start = 1'b0;
    chk("t5 busy", bus.search_busy, 1);
    chk("t5 code_valid drop", bus.code_valid, 0);
    chk("t5 align", bus.parser_align, 1);
    cyc = 1;
    s0  = nshift;
    wait_code("t5b", s0, 0, 0, cyc);
    chk("t5b latency", cyc, 6);
    pop_cmp("t5b");
    ack();

    // Softreset while scanning.
    bq = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    load(bq, 0);
    s0 = nshift;
    start_pulse(cyc);
    wait_shifts("t6", s0, 2);
    softreset = 1'b1;
    #1;
    chk("t6 shift gated", bus.parser_shift, 0);
    chk("t6 align gated", bus.parser_align, 0);
    snap = nshift;
    @(negedge clk);
    softreset = 1'b0;
    chk("t6 busy", bus.search_busy, 0);
    chk("t6 code_valid", bus.code_valid, 0);
    chk("t6 no shift", nshift, snap);

    // Async reset while in CODE.
    bq = {8'h00, 8'h00, 8'h01, 8'hC4, 8'hFF, 8'hFF};
    load(bq, 0);
    s0 = nshift;
    start_pulse(cyc);
    wait_shifts("t7", s0, 3);
    chk("t7 in CODE", bus.parser_shift, 1);
    reset = 1'b1;
    #1;
    chk("t7 busy", bus.search_busy, 0);
    chk("t7 code_valid", bus.code_valid, 0);
    chk("t7 shift", bus.parser_shift, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t7 idle after reset", bus.search_busy, 0);

    chk("strobes together", nboth, 0);
    chk("strobe without valid", nbad, 0);
    chk("scoreboard drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/m2v_stcode.md
Name: m2v_stcode

Overview:
- Start-code scanner sitting directly downstream of the MPEG2 input stream buffer inside m2vdec.
- On request, it byte-aligns the bit pointer and consumes bytes until it finds the prefix 0x00 0x00 0x01.
- It then consumes the following byte, presents it as the start-code value and holds it until the header parser acknowledges.
- It drives the buffer's parser_shift/parser_width/parser_align inputs while it owns the stream.

Parameters:
- SKIPCNT_WIDTH, 16, width of the skipped-byte counter (used only with the optional feature).

Ports:
- clk            in   1   system clock
- reset          in   1   asynchronous reset, active-high
- softreset      in   1   synchronous flush, same as the buffer's softreset
- buffer_data    in   13  MSB-first window from the stream buffer; the current byte is [12:5]
- buffer_valid   in   1   window holds at least 13 valid bits
- parser_shift   out  1   consume parser_width bits this cycle
- parser_width   out  4   shift amount; always 4'd8 in this block
- parser_align   out  1   advance to the next byte boundary
- search_start   in   1   pulse; begin a start-code search
- search_busy    out  1   high in ALIGN, SCAN or CODE
- code_valid     out  1   start code found; held until code_ack
- code_value     out  8   byte following the 0x000001 prefix
- code_ack       in   1   consumer accepted code_value
- skip_count     out  SKIPCNT_WIDTH  bytes discarded before the prefix (optional feature)

Behaviour:
- FSM states: IDLE, ALIGN, SCAN, CODE, FOUND.
- Reset (async, asserted) or softreset (sync): state goes to IDLE.
  - zcnt=0, code_valid=0, code_value=8'h00, search_busy=0, skip_count=0.
  - parser_shift=0 and parser_align=0 in the same cycle softreset is high.
- parser_width is the constant 4'd8.
- Shift/align strobes are combinational from state and buffer_valid, because the buffer uses them in the same cycle.
  - parser_align = (state==ALIGN) & buffer_valid.
  - parser_shift = (state==SCAN | state==CODE) & buffer_valid.
  - parser_align and parser_shift are never high together.
- IDLE: search_start -> ALIGN, zcnt<=0, skip_count<=0.
- ALIGN: when buffer_valid, assert parser_align for exactly one cycle -> SCAN. If buffer_valid is low, wait.
- SCAN: each cycle with buffer_valid, shift 8 and classify byte b=buffer_data[12:5]:
  - b==8'h00: zcnt<=min(zcnt+1,2), saturating 2-bit counter.
  - b==8'h01 and zcnt==2: -> CODE, zcnt<=0.
  - otherwise: zcnt<=0, skip_count+=1.
  - A 0x00 byte that later turns out not to be part of a prefix is still counted in skip_count when the run breaks; add zcnt+1 on that break.
  - Leading extra zeros (e.g. 00 00 00 01) are valid stuffing and are not counted as skipped.
- SCAN with buffer_valid low: no shift, no state change. Stalls of any length are allowed.
- CODE: on buffer_valid, shift 8, code_value<=buffer_data[12:5], code_valid<=1 -> FOUND.
  - code_valid rises the cycle after the code byte is consumed.
- FOUND: no shifting; code_valid and code_value are stable.
  - code_ack -> IDLE, code_valid<=0.
  - code_ack & search_start in the same cycle -> ALIGN directly; code_valid drops.
- search_start outside IDLE/FOUND is ignored. search_start in FOUND without code_ack is ignored.
- code_ack outside FOUND is ignored.
- search_busy = state in {ALIGN, SCAN, CODE}.
- Throughput: one byte per clock while buffer_valid stays high.
- Latency from search_start to code_valid, with continuous data and the prefix at the first aligned byte: 6 cycles.
  - 1 cycle IDLE->ALIGN, 1 align, 3 prefix bytes, 1 code byte, with code_valid registered at the end.
- skip_count saturates at all-ones and never wraps.

Optional Feature:
- Macro M2V_STCODE_SKIPCNT_EN.
- Defined: skip_count is implemented as described.
- Undefined: the counter logic is removed and skip_count is tied to 0. All other behaviour is identical.

Test Plan:
- Aligned stream 00 00 01 B3, pulse search_start -> exactly 4 parser_shift pulses, code_valid=1 with code_value=8'hB3 on the 6th cycle, skip_count=0; hold until code_ack, then IDLE.
- Pointer at bit offset 3, stream 47 00 00 00 01 00 -> one parser_align, then shifts; code_value=8'h00, skip_count=1 (the zero stuffing is not counted).
- False prefixes 00 01 00 00 02 00 00 01 B8 -> code_value=8'hB8, skip_count=5.
- buffer_valid low for 10 cycles mid-prefix (after 00 00) -> no parser_shift while low, zcnt retained, code found once data resumes.
- code_ack and search_start in the same FOUND cycle -> next cycle state ALIGN, code_valid=0, next code found without an IDLE cycle.
- softreset asserted in SCAN -> parser_shift=0 in that cycle, next cycle IDLE, search_busy=0, code_valid=0. Async reset mid-CODE gives the same result immediately.
